apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- Upstream neighbour of the APB memory slave: converts a simple valid/ready command stream (from CPU model, DMA or test sequencer) into APB SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response channel.
- Adds a bounded wait on pready: a hung slave produces an error response instead of a deadlock.
- One transfer outstanding at a time.

Parameters:
- w, 8, data width (pw_data, pr_data, cmd_wdata, rsp_rdata).
- d, 8, address width (paddr, cmd_addr).
- TIMEOUT, 16, max ACCESS cycles with pready low before abort; legal range 2..255.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- preset  input  1  asynchronous, active-low reset; assertion immediately clears all state and outputs.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at rising edge.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  d  target address.
- cmd_wdata  input  w  write data (ignored for reads).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  output  w  read data; 0 for writes and aborted transfers.
- rsp_err  output  1  slave pslverr or timeout.
- rsp_timeout  output  1  transfer aborted by timeout.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  d  APB address.
- pw_data  output  w  APB write data.
- pr_data  input  w  APB read data.
- pready  input  1  APB ready.
- pslverr  input  1  APB slave error.

Behaviour:
- Reset (preset low, async): state IDLE.
  - psel, penable, pwrite, paddr, pw_data, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, wait counter all 0.
  - cmd_ready is 0 while preset is low.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered except cmd_ready (= state==IDLE, and preset high).
- IDLE:
  - cmd_ready=1, psel=0, penable=0.
  - On handshake: latch cmd_write/addr/wdata into pwrite/paddr/pw_data, clear the counter, go to SETUP.
- SETUP: exactly one cycle with psel=1, penable=0, then ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - pready and pslverr are sampled only in this state.
  - If pready=1: capture pr_data into rsp_rdata (read) or 0 (write); rsp_err=pslverr; rsp_timeout=0; go to RESP.
  - Else the counter increments. When the counter reaches TIMEOUT-1 and pready is still low: rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP. ACCESS therefore lasts at most TIMEOUT cycles.
- RESP:
  - psel=0, penable=0, rsp_valid=1; response fields held stable.
  - On rsp_ready: rsp_valid=0, go to IDLE.
  - cmd_ready stays 0 throughout RESP, so a command presented during RESP is accepted no earlier than the first IDLE cycle.
- Latency, zero-wait slave:
  - Handshake at edge N.
  - psel high in cycle N+1; penable high in cycle N+2.
  - rsp_valid high in cycle N+3.
  - Minimum 4 cycles per transfer with rsp_ready tied high.
- Stability:
  - pwrite/paddr/pw_data stay constant from SETUP through end of ACCESS.
  - pw_data, paddr and pwrite hold their last values while idle.
- pslverr with pready=0 is ignored.
- A pready pulse during SETUP is ignored.
- Reset mid-transfer: bus returns to idle asynchronously; the in-flight command is dropped with no response.
- Counter width: 8 bits, no wrap possible within the legal TIMEOUT range.

Test Plan:
- Write, zero-wait slave: cmd addr=8'h03, wdata=8'hA5, pready=1 → psel at N+1, penable at N+2, paddr=03 and pw_data=A5 stable; rsp_valid at N+3, rsp_err=0, rsp_rdata=00.
- Read-back: read addr=8'h03 after the write above → rsp_rdata=8'hA5, rsp_err=0.
- Wait states: slave holds pready low 3 ACCESS cycles → penable high for 4 cycles, address stable, response one cycle after pready.
- Slave error: write addr=8'h17, slave returns pslverr=1 with pready → rsp_err=1, rsp_timeout=0.
- Timeout: pready tied 0, TIMEOUT=16 → penable high exactly 16 cycles, then rsp_err=1, rsp_timeout=1, rsp_rdata=00; psel drops.
- Backpressure/reset: hold rsp_ready=0 for 5 cycles with a queued cmd_valid → cmd_ready stays 0, response stable. Separately, drop preset during ACCESS → psel/penable/rsp_valid go 0 immediately with no response.

Source files
------------

// File: rtl/apb_cmd_master.sv
// Command-stream to APB master: one transfer in flight, handshake-to-rsp_valid is 3 cycles with a zero-wait slave.
// cmd_ready only in IDLE; the response holds until rsp_ready; a stalled pready aborts after TIMEOUT ACCESS cycles.
module apb_cmd_master #(
  parameter int w       = 8,
  parameter int d       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         preset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [d-1:0] cmd_addr,
  input  logic [w-1:0] cmd_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [w-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         rsp_timeout,
  output logic         psel,
  output logic         penable,
  output logic         pwrite,
  output logic [d-1:0] paddr,
  output logic [w-1:0] pw_data,
  input  logic [w-1:0] pr_data,
  input  logic         pready,
  input  logic         pslverr
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t         state, state_nxt;
  logic [7:0]     cnt, cnt_nxt;
  logic           psel_nxt, penable_nxt, pwrite_nxt, rsp_valid_nxt;
  logic           rsp_err_nxt, rsp_timeout_nxt;
  logic [d-1:0]   paddr_nxt;
  logic [w-1:0]   pw_data_nxt, rsp_rdata_nxt;

  assign cmd_ready = (state == IDLE) && preset;

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    pwrite_nxt      = pwrite;
    paddr_nxt       = paddr;
    pw_data_nxt     = pw_data;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_nxt  = cmd_write;
          paddr_nxt   = cmd_addr;
          pw_data_nxt = cmd_wdata;
          cnt_nxt     = 8'd0;
          state_nxt   = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        // pready wins over the timeout on the last allowed cycle
        if (pready) begin
          rsp_rdata_nxt   = pwrite ? '0 : pr_data;
          rsp_err_nxt     = pslverr;
          rsp_timeout_nxt = 1'b0;
          state_nxt       = RESP;
        end else if (cnt == CNT_LAST) begin
          rsp_rdata_nxt   = '0;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          state_nxt       = RESP;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    psel_nxt      = (state_nxt == SETUP) || (state_nxt == ACCESS);
    penable_nxt   = (state_nxt == ACCESS);
    rsp_valid_nxt = (state_nxt == RESP);
  end

  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pw_data     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      pwrite      <= pwrite_nxt;
      paddr       <= paddr_nxt;
      pw_data     <= pw_data_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: a configurable APB slave plus a transaction-level reference model
// predicting response data, error flags and ACCESS length for every command.
module tb_apb_cmd_master;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         preset;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [D-1:0] cmd_addr;
  logic [W-1:0] cmd_wdata;
  logic         rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [W-1:0] rsp_rdata;
  logic         psel, penable, pwrite;
  logic [D-1:0] paddr;
  logic [W-1:0] pw_data;
  logic [W-1:0] pr_data = '0;
  logic         pready = 1'b0;
  logic         pslverr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  apb_cmd_master #(.w(W), .d(D), .TIMEOUT(TO)) dut (
    .clk(clk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pw_data(pw_data), .pr_data(pr_data), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // Slave: pready rises after slv_wait low ACCESS cycles; junk on pready/pslverr elsewhere
  logic [7:0] slv_mem [256];
  logic [7:0] ref_mem [256];
  int slv_wait = 0;
  bit slv_err  = 0;
  bit slv_hang = 0;
  int acc_cyc  = 0;

  always @(negedge clk) begin
    if (psel === 1'b1 && penable === 1'b1) begin
      pready  = !slv_hang && (acc_cyc >= slv_wait);
      pslverr = pready ? slv_err : 1'($urandom);
      pr_data = slv_mem[paddr];
      if (pready && pwrite && !slv_err) slv_mem[paddr] = pw_data;
      acc_cyc++;
    end else begin
      acc_cyc = 0;
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      pr_data = 8'($urandom);
    end
  end

  // Transaction-level expectation; ref_mem tracks committed writes
  task automatic predict(input logic wr, input logic [7:0] a, input logic [7:0] wd, input int wt,
                         input bit serr, input bit hang, output logic [7:0] rd, output logic er,
                         output logic tmo, output int pen);
    if (hang || wt >= TO) begin
      rd = 8'h00; er = 1'b1; tmo = 1'b1; pen = TO;
    end else begin
      pen = wt + 1; er = serr; tmo = 1'b0;
      rd  = wr ? 8'h00 : ref_mem[a];
      if (wr && !serr) ref_mem[a] = wd;
    end
  endtask

  int         o_psel_first, o_pen_first, o_pen_cnt, o_rsp_first, o_rdy_wait;
  bit         o_done, o_stable, o_rsp_stable, o_cr_in_resp, o_bus_idle, o_cleared;
  logic [7:0] o_rdata;
  logic       o_err, o_to;
  logic       q_wr;
  logic [7:0] q_a, q_wd;

  // Drives one command and records what the bus and response did; called and returns at a negedge
  task automatic do_xfer(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                         input int hold, input bit queue);
    o_done = 0; o_psel_first = -1; o_pen_first = -1; o_pen_cnt = 0; o_rsp_first = -1;
    o_stable = 1; o_rsp_stable = 1; o_cr_in_resp = 0; o_bus_idle = 1; o_cleared = 0;
    o_rdy_wait = 0; o_rdata = 'x; o_err = 'x; o_to = 'x;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    while (cmd_ready !== 1'b1 && o_rdy_wait < 50) begin
      @(negedge clk);
      o_rdy_wait++;
    end
    if (cmd_ready !== 1'b1) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
    for (int c = 1; c <= 300; c++) begin
      if (psel === 1'b1 && o_psel_first < 0) o_psel_first = c;
      if (penable === 1'b1) begin
        o_pen_cnt++;
        if (o_pen_first < 0) o_pen_first = c;
      end
      if (psel === 1'b1 && (paddr !== a || pw_data !== wd || pwrite !== wr)) o_stable = 0;
      if (rsp_valid === 1'b1) begin
        o_rsp_first = c; o_rdata = rsp_rdata; o_err = rsp_err; o_to = rsp_timeout;
        if (psel !== 1'b0 || penable !== 1'b0) o_bus_idle = 0;
        for (int h = 0; h < hold; h++) begin
          if (queue) begin
            cmd_valid = 1'b1; cmd_write = q_wr; cmd_addr = q_a; cmd_wdata = q_wd;
          end
          @(negedge clk);
          if (rsp_valid !== 1'b1 || rsp_rdata !== o_rdata || rsp_err !== o_err ||
              rsp_timeout !== o_to) o_rsp_stable = 0;
          if (cmd_ready !== 1'b0) o_cr_in_resp = 1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        o_cleared = (rsp_valid === 1'b0);
        o_done = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    preset = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h5A; cmd_wdata = 8'hC3;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, cmd_ready} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, cmd_ready});
    end
    n_checks++;
    if (paddr !== 8'h00 || pw_data !== 8'h00) begin
      n_errors++; $display("FAIL reset_bus: got paddr=%h pw_data=%h expected 00/00", paddr, pw_data);
    end
    n_checks++;
    if (rsp_rdata !== 8'h00) begin
      n_errors++; $display("FAIL reset_rdata: got %h expected 00", rsp_rdata);
    end
    cmd_valid = 1'b0;
    preset = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_write_zero_wait();
    logic [7:0] erd; logic eer, eto; int epen;
    slv_wait = 0; slv_err = 0; slv_hang = 0;
    predict(1'b1, 8'h03, 8'hA5, 0, 0, 0, erd, eer, eto, epen);
    do_xfer(1'b1, 8'h03, 8'hA5, 0, 0);
    n_checks++;
    if (o_done !== 1) begin n_errors++; $display("FAIL wr0_done: got %0d expected 1", o_done); end
    n_checks++;
    if (o_psel_first != 1 || o_pen_first != 2 || o_rsp_first != 3) begin
      n_errors++;
      $display("FAIL wr0_latency: got psel@%0d pen@%0d rsp@%0d expected 1/2/3",
               o_psel_first, o_pen_first, o_rsp_first);
    end
    n_checks++;
    if (o_stable !== 1) begin n_errors++; $display("FAIL wr0_bus_stable: got %0d expected 1", o_stable); end
    n_checks++;
    if ({o_err, o_to, o_rdata} !== {eer, eto, erd}) begin
      n_errors++; $display("FAIL wr0_rsp: got err=%b to=%b rd=%h expected %b/%b/%h",
                           o_err, o_to, o_rdata, eer, eto, erd);
    end
    n_checks++;
    if (o_cleared !== 1) begin n_errors++; $display("FAIL wr0_rsp_clear: got %0d expected 1", o_cleared); end
  endtask

  task automatic test_read_back();
    logic [7:0] erd; logic eer, eto; int epen;
    slv_wait = 0; slv_err = 0; slv_hang = 0;
    predict(1'b0, 8'h03, 8'h00, 0, 0, 0, erd, eer, eto, epen);
    do_xfer(1'b0, 8'h03, 8'h00, 0, 0);
    n_checks++;
    if (o_done !== 1 || o_rdata !== 8'hA5 || o_err !== 1'b0) begin
      n_errors++; $display("FAIL readback: got done=%0d rd=%h err=%b expected 1/a5/0", o_done, o_rdata, o_err);
    end
  endtask

  task automatic test_wait_states();
    slv_wait = 3; slv_err = 0; slv_hang = 0;
    begin
      logic [7:0] erd; logic eer, eto; int epen;
      predict(1'b1, 8'h0B, 8'h6E, 3, 0, 0, erd, eer, eto, epen);
      do_xfer(1'b1, 8'h0B, 8'h6E, 0, 0);
      n_checks++;
      if (o_pen_cnt != 4 || o_rsp_first != 6) begin
        n_errors++; $display("FAIL wait3_timing: got pen=%0d rsp@%0d expected 4/6", o_pen_cnt, o_rsp_first);
      end
      n_checks++;
      if (o_stable !== 1 || o_err !== eer) begin
        n_errors++; $display("FAIL wait3_bus: got stable=%0d err=%b expected 1/%b", o_stable, o_err, eer);
      end
    end
  endtask

  task automatic test_slave_error();
    logic [7:0] erd; logic eer, eto; int epen;
    slv_wait = 0; slv_err = 1; slv_hang = 0;
    predict(1'b1, 8'h17, 8'h3C, 0, 1, 0, erd, eer, eto, epen);
    do_xfer(1'b1, 8'h17, 8'h3C, 0, 0);
    n_checks++;
    if (o_done !== 1 || o_err !== 1'b1 || o_to !== 1'b0) begin
      n_errors++; $display("FAIL slverr: got done=%0d err=%b to=%b expected 1/1/0", o_done, o_err, o_to);
    end
    slv_err = 0;
  endtask

  task automatic test_timeout();
    logic [7:0] erd; logic eer, eto; int epen;
    slv_hang = 1;
    predict(1'b0, 8'h21, 8'h00, 0, 0, 1, erd, eer, eto, epen);
    do_xfer(1'b0, 8'h21, 8'h00, 0, 0);
    n_checks++;
    if (o_pen_cnt != TO || o_rsp_first != TO + 2) begin
      n_errors++; $display("FAIL timeout_len: got pen=%0d rsp@%0d expected %0d/%0d",
                           o_pen_cnt, o_rsp_first, TO, TO + 2);
    end
    n_checks++;
    if ({o_err, o_to, o_rdata} !== {eer, eto, erd}) begin
      n_errors++; $display("FAIL timeout_rsp: got err=%b to=%b rd=%h expected %b/%b/%h",
                           o_err, o_to, o_rdata, eer, eto, erd);
    end
    n_checks++;
    if (o_bus_idle !== 1) begin n_errors++; $display("FAIL timeout_psel_drop: got %0d expected 1", o_bus_idle); end
    slv_hang = 0;
  endtask

  task automatic test_backpressure();
    logic [7:0] erd; logic eer, eto; int epen;
    slv_wait = 1; slv_err = 0; slv_hang = 0;
    q_wr = 1'b0; q_a = 8'h03; q_wd = 8'h77;
    predict(1'b1, 8'h05, 8'hE1, 1, 0, 0, erd, eer, eto, epen);
    do_xfer(1'b1, 8'h05, 8'hE1, 5, 1);
    n_checks++;
    if (o_rsp_stable !== 1) begin n_errors++; $display("FAIL bp_rsp_stable: got %0d expected 1", o_rsp_stable); end
    n_checks++;
    if (o_cr_in_resp !== 0) begin n_errors++; $display("FAIL bp_cmd_ready: got %0d expected 0", o_cr_in_resp); end
    slv_wait = 0;
    predict(q_wr, q_a, q_wd, 0, 0, 0, erd, eer, eto, epen);
    do_xfer(q_wr, q_a, q_wd, 0, 0);
    n_checks++;
    if (o_rdy_wait != 0 || o_rdata !== erd) begin
      n_errors++; $display("FAIL bp_queued: got wait=%0d rd=%h expected 0/%h", o_rdy_wait, o_rdata, erd);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    slv_hang = 1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h42; cmd_wdata = 8'h99;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (penable !== 1'b1) begin n_errors++; $display("FAIL rstmid_in_access: got %b expected 1", penable); end
    #2 preset = 1'b0;
    #1;
    n_checks++;
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0 || paddr !== 8'h00) begin
      n_errors++; $display("FAIL rstmid_async: got psel=%b pen=%b rv=%b cr=%b paddr=%h expected 0/0/0/0/00",
                           psel, penable, rsp_valid, cmd_ready, paddr);
    end
    @(negedge clk);
    preset = 1'b1;
    slv_hang = 0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || psel !== 1'b0) seen = 1;
    end
    n_checks++;
    if (seen !== 0) begin n_errors++; $display("FAIL rstmid_no_rsp: got %0d expected 0", seen); end
  endtask

  task automatic test_random();
    logic [7:0] erd, a, wd; logic eer, eto, wr; int epen, wt, r, hold; bit serr;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1)); a = 8'($urandom_range(0, 15)); wd = 8'($urandom);
      r = $urandom_range(0, 9);
      wt = (r < 6) ? $urandom_range(0, 3) : (r < 8) ? $urandom_range(TO - 3, TO + 3) : 0;
      serr = ($urandom_range(0, 7) == 0);
      hold = $urandom_range(0, 2);
      slv_wait = wt; slv_err = serr; slv_hang = 0;
      predict(wr, a, wd, wt, serr, 0, erd, eer, eto, epen);
      do_xfer(wr, a, wd, hold, 0);
      n_checks++;
      if (o_done !== 1 || {o_err, o_to, o_rdata} !== {eer, eto, erd}) begin
        n_errors++; $display("FAIL rand_rsp[%0d]: got done=%0d err=%b to=%b rd=%h expected 1/%b/%b/%h",
                             i, o_done, o_err, o_to, o_rdata, eer, eto, erd);
      end
      n_checks++;
      if (o_pen_cnt != epen || o_rsp_first != epen + 2 || o_stable !== 1) begin
        n_errors++; $display("FAIL rand_timing[%0d]: got pen=%0d rsp@%0d stable=%0d expected %0d/%0d/1",
                             i, o_pen_cnt, o_rsp_first, o_stable, epen, epen + 2);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = 8'($urandom);
      ref_mem[i] = slv_mem[i];
    end
    test_reset();
    test_write_zero_wait();
    test_read_back();
    test_wait_states();
    test_slave_error();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: got no completion by t=500000 expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
